key_conditioner: RTL and testbench



---
 rtl/key_conditioner.sv | 137 +++++++++++++
 tb/tb_key_conditioner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - push-button synchroniser, debouncer and auto-repeat pulse generator
//
// Purpose: turns one raw clock-setting button into a debounced level and
// single-cycle step pulses (one per press, plus auto-repeat while held).
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   btn_raw    in   raw asynchronous button pin
//   key_level  out  debounced pressed state, 1 = pressed
//   key_pulse  out  one-cycle strobe on press and on each auto-repeat
//   key_repeat out  high while auto-repeating

module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int ENABLE_REPEAT   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic key_level,
  output logic key_pulse,
  output logic key_repeat
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW      = $clog2(CNT_MAX);
  localparam int DW      = $clog2(DEBOUNCE_CYCLES);

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, HELD_WAIT, REPEATING} state_t;

  logic          btn_n;
  logic          s1, s2;
  logic [DW-1:0] db_cnt;
  logic          db_accept, level_rise, level_fall;

  state_t        state, state_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic          pulse_n, repeat_n;

  assign btn_n = btn_raw ^ (ACTIVE_LOW != 0);

  // The FSM reacts on the same edge the debounced level changes, so it
  // looks at the debouncer's decision rather than at a delayed copy.
  assign db_accept  = (s2 != key_level) && (db_cnt == DB_LAST);
  assign level_rise = db_accept & s2;
  assign level_fall = db_accept & ~s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      db_cnt    <= '0;
      key_level <= 1'b0;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
      if (s2 == key_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_level <= s2;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RELEASED;
      hold_cnt   <= '0;
      key_pulse  <= 1'b0;
      key_repeat <= 1'b0;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_cnt_n;
      key_pulse  <= pulse_n;
      key_repeat <= repeat_n;
    end
  end

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    pulse_n    = 1'b0;
    case (state)
      RELEASED: begin
        if (level_rise) begin
          pulse_n    = 1'b1;
          state_n    = HELD_WAIT;
          hold_cnt_n = '0;
        end
      end
      HELD_WAIT: begin
        // Release is checked first so it beats a due pulse on the same edge.
        if (level_fall) begin
          state_n    = RELEASED;
          hold_cnt_n = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          // Without repeat the counter parks here until release.
          if (ENABLE_REPEAT != 0) begin
            pulse_n    = 1'b1;
            state_n    = REPEATING;
            hold_cnt_n = '0;
          end
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      REPEATING: begin
        if (level_fall) begin
          state_n    = RELEASED;
          hold_cnt_n = '0;
        end else if (hold_cnt == REPEAT_LAST) begin
          pulse_n    = 1'b1;
          hold_cnt_n = '0;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n    = RELEASED;
        hold_cnt_n = '0;
      end
    endcase
    repeat_n = (state_n == REPEATING);
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - scoreboard bench for key_conditioner

module tb_key_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_a = 1'b0;
  logic btn_b = 1'b1;
  logic level_a, pulse_a, repeat_a;
  logic level_b, pulse_b, repeat_b;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int exp_a[$];
  int exp_b[$];
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  key_conditioner #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3),
    .ACTIVE_LOW(0), .ENABLE_REPEAT(1)
  ) dut_a (
    .clk(clk), .reset(reset), .btn_raw(btn_a),
    .key_level(level_a), .key_pulse(pulse_a), .key_repeat(repeat_a)
  );

  key_conditioner #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3),
    .ACTIVE_LOW(1), .ENABLE_REPEAT(0)
  ) dut_b (
    .clk(clk), .reset(reset), .btn_raw(btn_b),
    .key_level(level_b), .key_pulse(pulse_b), .key_repeat(repeat_b)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Pulse monitors: every observed pulse must match the next expected edge.
  always begin
    int e;
    @(posedge clk);
    #1;
    if (pulse_a) begin
      tests++;
      if (exp_a.size() == 0) begin
        fails++;
        $display("FAIL pulse_a: unexpected pulse at edge %0d, none expected", cyc);
      end else begin
        e = exp_a.pop_front();
        if (e != cyc) begin
          fails++;
          $display("FAIL pulse_a: pulse at edge %0d, expected edge %0d", cyc, e);
        end
      end
      if (prev_a) begin
        fails++;
        $display("FAIL pulse_a_consecutive: high at edge %0d and previous edge", cyc);
      end
    end
    prev_a = pulse_a;
  end

  always begin
    int e;
    @(posedge clk);
    #1;
    if (pulse_b) begin
      tests++;
      if (exp_b.size() == 0) begin
        fails++;
        $display("FAIL pulse_b: unexpected pulse at edge %0d, none expected", cyc);
      end else begin
        e = exp_b.pop_front();
        if (e != cyc) begin
          fails++;
          $display("FAIL pulse_b: pulse at edge %0d, expected edge %0d", cyc, e);
        end
      end
      if (prev_b) begin
        fails++;
        $display("FAIL pulse_b_consecutive: high at edge %0d and previous edge", cyc);
      end
    end
    prev_b = pulse_b;
  end

  initial begin
    int p;
    int c;

    // Reset state of both instances
    at(3);
    check("rst_level_a", level_a, 0);
    check("rst_pulse_a", pulse_a, 0);
    check("rst_repeat_a", repeat_a, 0);
    check("rst_level_b", level_b, 0);
    check("rst_pulse_b", pulse_b, 0);
    check("rst_repeat_b", repeat_b, 0);
    reset = 1'b0;

    // Clean press, released before the first repeat is due
    at(6);
    btn_a = 1'b1;
    p = cyc + 6;
    exp_a.push_back(p);
    at(p - 1); check("t1_level_before", level_a, 0);
    at(p);     check("t1_level_rise", level_a, 1);
               check("t1_pulse", pulse_a, 1);
    at(p + 1); check("t1_pulse_one_cycle", pulse_a, 0);
    at(p + 2); btn_a = 1'b0;
    at(p + 7); check("t1_level_held", level_a, 1);
    at(p + 8); check("t1_level_fall", level_a, 0);
               check("t1_repeat", repeat_a, 0);
    at(p + 15);

    // Bounce: 3 high / 1 low never reaches the stable count
    for (int i = 0; i < 10; i++) begin
      btn_a = 1'b1;
      at(cyc + 3);
      btn_a = 1'b0;
      at(cyc + 1);
      check("t2_bounce_level", level_a, 0);
    end
    at(cyc + 10);

    // Long hold: press, hold pulse, repeats
    btn_a = 1'b1;
    p = cyc + 6;
    exp_a.push_back(p);
    exp_a.push_back(p + 10);
    exp_a.push_back(p + 13);
    exp_a.push_back(p + 16);
    exp_a.push_back(p + 19);
    exp_a.push_back(p + 22);
    exp_a.push_back(p + 25);
    exp_a.push_back(p + 28);
    at(p + 9);  check("t3_repeat_before", repeat_a, 0);
    at(p + 10); check("t3_repeat_start", repeat_a, 1);
    at(p + 24); btn_a = 1'b0;
    at(p + 29); check("t3_repeat_held", repeat_a, 1);
                check("t3_level_held", level_a, 1);
    at(p + 30); check("t3_level_fall", level_a, 0);
                check("t3_repeat_end", repeat_a, 0);
    at(p + 40);

    // Release on the same edge a repeat pulse is due
    btn_a = 1'b1;
    p = cyc + 6;
    exp_a.push_back(p);
    exp_a.push_back(p + 10);
    exp_a.push_back(p + 13);
    at(p + 10); btn_a = 1'b0;
    at(p + 15); check("t4_repeat_before", repeat_a, 1);
    at(p + 16); check("t4_level_fall", level_a, 0);
                check("t4_repeat_off", repeat_a, 0);
                check("t4_no_pulse", pulse_a, 0);
    at(p + 30);

    // Reset while held: schedule restarts from the post-reset press
    btn_a = 1'b1;
    p = cyc + 6;
    exp_a.push_back(p);
    exp_a.push_back(p + 10);
    at(p + 11); reset = 1'b1;
    at(p + 12); check("t5_rst_level", level_a, 0);
                check("t5_rst_pulse", pulse_a, 0);
                check("t5_rst_repeat", repeat_a, 0);
    at(p + 13); check("t5_rst_level2", level_a, 0);
                reset = 1'b0;
    exp_a.push_back(p + 19);
    exp_a.push_back(p + 29);
    exp_a.push_back(p + 32);
    at(p + 18); check("t5_level_before", level_a, 0);
    at(p + 19); check("t5_level_rise", level_a, 1);
    at(p + 28); check("t5_repeat_before", repeat_a, 0);
                btn_a = 1'b0;
    at(p + 29); check("t5_repeat_start", repeat_a, 1);
    at(p + 34); check("t5_level_fall", level_a, 0);
                check("t5_repeat_end", repeat_a, 0);
    at(p + 45);

    // Active-low, no repeat: one pulse per press only
    check("t6_idle_level", level_b, 0);
    c = cyc;
    btn_b = 1'b0;
    p = c + 6;
    exp_b.push_back(p);
    at(p - 1);  check("t6_level_before", level_b, 0);
    at(p);      check("t6_level_rise", level_b, 1);
                check("t6_pulse", pulse_b, 1);
    at(p + 15); check("t6_repeat_mid", repeat_b, 0);
    at(c + 40); btn_b = 1'b1;
    at(c + 45); check("t6_level_held", level_b, 1);
                check("t6_repeat_late", repeat_b, 0);
    at(c + 46); check("t6_level_fall", level_b, 0);
    at(c + 60);

    check("exp_a_drained", exp_a.size(), 0);
    check("exp_b_drained", exp_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
